// File: rtl/divider_seq.sv
// Sequential radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU ops.
// One quotient bit per cycle, then a single sign-fix cycle.
module divider_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = (XLEN > 2) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvsr;
  logic [XLEN-1:0] a_q;
  logic            sel_rem;
  logic            neg_q;
  logic            neg_r;
  logic            div0;
  logic            ovf;

  logic            sgn;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN-1:0] res_nxt;

  assign sgn   = ~op[0];
  assign a_abs = (sgn && a[XLEN-1]) ? -a : a;
  assign b_abs = (sgn && b[XLEN-1]) ? -b : b;

  assign rem_sh = {rem, quo[XLEN-1]};
  assign diff   = rem_sh - {1'b0, dvsr};

  assign q_fix = neg_q ? -quo : quo;
  assign r_fix = neg_r ? -rem : rem;

  // Divide-by-zero and signed overflow bypass the sign fix entirely.
  always_comb begin
    res_nxt = sel_rem ? r_fix : q_fix;
    if (div0) begin
      res_nxt = sel_rem ? a_q : '1;
    end else if (ovf) begin
      res_nxt = sel_rem ? '0 : a_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      quo     <= '0;
      rem     <= '0;
      dvsr    <= '0;
      a_q     <= '0;
      sel_rem <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      div0    <= 1'b0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            quo     <= a_abs;
            rem     <= '0;
            cnt     <= '0;
            dvsr    <= b_abs;
            a_q     <= a;
            sel_rem <= op[1];
            neg_q   <= sgn & (a[XLEN-1] ^ b[XLEN-1]);
            neg_r   <= sgn & a[XLEN-1];
            div0    <= (b == '0);
            ovf     <= sgn && (a == {1'b1, {(XLEN-1){1'b0}}})
                           && (b == '1);
            busy    <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          // The dividend drains out of quo's MSB as quotient bits fill its LSB.
          quo <= {quo[XLEN-2:0], ~diff[XLEN]};
          rem <= diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          result <= res_nxt;
          busy   <= 1'b0;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq.sv
// Directed-vector bench for divider_seq: values, latency, busy, start
// masking and mid-operation reset.
module tb_divider_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_chk;
  int n_pass;

  localparam logic [1:0] DIV  = 2'b00;
  localparam logic [1:0] DIVU = 2'b01;
  localparam logic [1:0] REM  = 2'b10;
  localparam logic [1:0] REMU = 2'b11;

  divider_seq #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Issues one op and watches 45 edges; optionally re-pulses start mid-CALC.
  task automatic run(input logic [1:0] o, input logic [31:0] x,
                     input logic [31:0] y, input bit repulse,
                     output int lat, output logic [31:0] res,
                     output int ndone, output logic busy32,
                     output logic busy33);
    lat    = -1;
    res    = '0;
    ndone  = 0;
    busy32 = 1'b0;
    busy33 = 1'b1;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 1; n <= 45; n++) begin
      if (repulse && n == 6) begin
        start = 1'b1;
        op    = DIVU;
        a     = 32'd1000;
        b     = 32'd3;
      end
      if (repulse && n == 7) start = 1'b0;
      @(posedge clk);
      #1;
      if (n == 32) busy32 = busy;
      if (n == 33) busy33 = busy;
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = n;
          res = result;
        end
      end
    end
  endtask

  task automatic vec(input string tag, input logic [1:0] o,
                     input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] exp);
    int          lat;
    int          nd;
    logic [31:0] res;
    logic        b32;
    logic        b33;
    run(o, x, y, 1'b0, lat, res, nd, b32, b33);
    chk({tag, "_res"}, res, exp);
    chk({tag, "_lat"}, lat, 34);
  endtask

  initial begin
    int          lat;
    int          nd;
    logic [31:0] res;
    logic        b32;
    logic        b33;
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    op     = DIV;
    a      = '0;
    b      = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(DIVU, 32'd100, 32'd7, 1'b0, lat, res, nd, b32, b33);
    chk("divu_res", res, 32'h0000000E);
    chk("divu_lat", lat, 34);
    chk("divu_ndone", nd, 1);
    chk("busy_fix", {31'd0, b32}, 32'd1);
    chk("busy_done", {31'd0, b33}, 32'd0);
    chk("result_hold", result, 32'h0000000E);

    vec("remu", REMU, 32'd100, 32'd7, 32'h00000002);
    vec("div_neg", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
    vec("rem_neg", REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
    vec("div_negb", DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD);
    vec("rem_negb", REM, 32'd7, 32'hFFFFFFFE, 32'h00000001);
    vec("div_by0", DIV, 32'h12345678, 32'd0, 32'hFFFFFFFF);
    vec("rem_by0", REM, 32'h12345678, 32'd0, 32'h12345678);
    vec("divu_by0", DIVU, 32'h80000005, 32'd0, 32'hFFFFFFFF);
    vec("rem_by0n", REM, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9);
    vec("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    vec("rem_ovf", REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);
    vec("divu_max", DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF);
    vec("divu_big", DIVU, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    vec("remu_big", REMU, 32'hFFFFFFFF, 32'h00010000, 32'h0000FFFF);

    run(DIVU, 32'd100, 32'd7, 1'b1, lat, res, nd, b32, b33);
    chk("repulse_res", res, 32'h0000000E);
    chk("repulse_lat", lat, 34);
    chk("repulse_ndone", nd, 1);

    @(negedge clk);
    start = 1'b1;
    op    = DIVU;
    a     = 32'd500;
    b     = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_result", result, 32'd0);
    nd = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_ndone", nd, 0);

    run(DIVU, 32'd100, 32'd7, 1'b0, lat, res, nd, b32, b33);
    chk("post_rst_res", res, 32'h0000000E);
    chk("post_rst_lat", lat, 34);
    chk("post_rst_ndone", nd, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/divider_seq.md
DIVIDER_SEQ -- requirements
Module: divider_seq

Interface
REQ-001 Parameter XLEN, default 32, operand and result width in bits.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (RV32M encoding order).
REQ-006 a  input  XLEN  dividend, captured on the accepting edge.
REQ-007 b  input  XLEN  divisor, captured on the accepting edge.
REQ-008 busy  output  1  high while an operation is in CALC or FIX.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 result  output  XLEN  quotient or remainder per op; registered.

Function
REQ-011 The FSM SHALL have the states IDLE, CALC, FIX and DONE.
REQ-012 IDLE: on start=1, the block SHALL latch a, b and op, and absolute values for signed ops. It SHALL clear the quotient, set the remainder to 0 and the step counter to 0, then go to CALC.
REQ-013 CALC SHALL perform one restoring step per cycle, as follows:
- shift {rem, dividend} left by 1;
- compute diff = rem - divisor on XLEN+1 bits;
- if diff is non-negative, rem = diff and the quotient bit is 1; otherwise rem is unchanged and the bit is 0.
REQ-014 CALC SHALL last exactly XLEN cycles, with the counter wrapping from XLEN-1 into FIX.
REQ-015 FIX SHALL apply sign correction for DIV/REM, register result, and go to DONE:
- quotient is negated when the operand signs differ;
- remainder takes the sign of the dividend.
REQ-016 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-017 Latency: done SHALL be high in the cycle that begins XLEN+2 edges after the start-sampling edge (34 for XLEN=32), for every operand value.
REQ-018 busy SHALL be high in CALC and FIX, and low in IDLE and DONE.
REQ-019 start SHALL be ignored in CALC, FIX and DONE, with no queuing.
REQ-020 Divide by zero (b=0, flagged at accept) SHALL give quotient all-ones and remainder = a unchanged, with sign correction bypassed and the same latency.
REQ-021 Signed overflow (DIV/REM, a=most-negative, b=all-ones) SHALL give quotient = a and remainder = 0, with the same latency.
REQ-022 result SHALL hold its value from the DONE cycle until the FIX of the next accepted operation.
REQ-023 All arithmetic SHALL be two's complement modulo 2^XLEN, with no exceptions or flags raised.

Reset
REQ-024 When rst_n=0, the block SHALL immediately go to IDLE and clear busy, done, result, the counter and all internal registers to 0.
REQ-025 A reset mid-operation SHALL abort it without a done pulse.
REQ-026 The first start after rst_n rises SHALL be accepted normally.

Verification
REQ-027 DIVU, a=100, b=7 -> done exactly 34 edges after start; result=0x0000000E. Repeat with REMU -> 0x00000002.
REQ-028 DIV, a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD (-3). REM with the same operands -> 0xFFFFFFFF (-1).
REQ-029 DIV, a=0x12345678, b=0 -> 0xFFFFFFFF. REM with the same operands -> 0x12345678. Both at 34-cycle latency.
REQ-030 DIV, a=0x80000000, b=0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0x00000000.
REQ-031 start re-pulsed during CALC with different operands -> ignored: first result 14 unchanged, single done pulse.
REQ-032 rst_n low at cycle 10 of CALC -> busy=0, done=0, result=0 before the next edge. A new DIVU 100/7 then completes with 14 in 34 cycles.
